ecc_32_err_scrub: RTL and testbench

- Sits directly downstream of the 32-bit SECDED decoder (39-bit codeword: 32 data + 7 check).
- Consumes the decoder's per-read result (corrected codeword, syndrome, SGL/DBL flags) tagged with the read address.
- Keeps saturating single- and double-error counts and captures an error log entry.
- Queues corrected single-error words as scrub write-back requests through a valid/ready FIFO toward the memory write port.

---
 rtl/ecc_32_err_scrub.sv | 203 ++++++++++++++++++++
 tb/tb_ecc_32_err_scrub.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_32_err_scrub.sv
// rtl/ecc_32_err_scrub.sv - SECDED error statistics, error log and scrub write-back queue
//
// Sits behind the 32-bit SECDED decoder (39-bit codeword). Counts single and
// double errors (saturating), keeps one error log entry with uncorrectable
// errors taking priority, and queues corrected single-error words as scrub
// write-back requests through a first-word-fall-through FIFO.
//
// Optional feature macro: ECC_SCRUB_DEDUP_EN
//   defined   - a single event whose address already sits in the queue (and is
//               not being popped this cycle) refreshes that entry's data
//               instead of pushing a new one.
//   undefined - every single event pushes its own entry.
//
// Ports:
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_in_vld                   decoder result valid (always accepted)
//   i_in_addr/data/syn         read address, corrected codeword, syndrome
//   i_in_sgl, i_in_dbl         single (corrected) / double (uncorrectable) flag
//   i_clr                      clears counters, log, irq and drop (not the FIFO)
//   o_scrb_vld, i_scrb_rdy     scrub request handshake
//   o_scrb_addr, o_scrb_data   scrub target address and codeword
//   o_sgl_cnt, o_dbl_cnt       saturating error counters
//   o_log_vld/addr/syn/dbl     error log entry
//   o_irq                      sticky, any double error
//   o_drop                     sticky, scrub request lost to a full FIFO
module ecc_32_err_scrub #(
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_in_vld,
  input  logic [ADDR_W-1:0] i_in_addr,
  input  logic [38:0]       i_in_data,
  input  logic [6:0]        i_in_syn,
  input  logic              i_in_sgl,
  input  logic              i_in_dbl,
  input  logic              i_clr,
  output logic              o_scrb_vld,
  input  logic              i_scrb_rdy,
  output logic [ADDR_W-1:0] o_scrb_addr,
  output logic [38:0]       o_scrb_data,
  output logic [CNT_W-1:0]  o_sgl_cnt,
  output logic [CNT_W-1:0]  o_dbl_cnt,
  output logic              o_log_vld,
  output logic [ADDR_W-1:0] o_log_addr,
  output logic [6:0]        o_log_syn,
  output logic              o_log_dbl,
  output logic              o_irq,
  output logic              o_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [38:0]       r_mem_data [FIFO_DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;

  logic [CNT_W-1:0]  r_sgl_cnt;
  logic [CNT_W-1:0]  r_dbl_cnt;
  logic              r_log_vld;
  logic              r_log_dbl;
  logic [ADDR_W-1:0] r_log_addr;
  logic [6:0]        r_log_syn;
  logic              r_irq;
  logic              r_drop;

  logic              w_sgl_ev;
  logic              w_dbl_ev;
  logic              w_any_ev;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_rd_idx;
  logic [PTR_W:0]    w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic [FIFO_DEPTH-1:0] w_dedup_hit;
  logic              w_dedup;
  logic [CNT_W-1:0]  w_sgl_base;
  logic [CNT_W-1:0]  w_dbl_base;
  logic              w_log_vld_base;
  logic              w_log_dbl_base;
  logic              w_log_cap;

  // Double wins over single when both flags are set
  assign w_dbl_ev = i_in_vld & i_in_dbl;
  assign w_sgl_ev = i_in_vld & i_in_sgl & ~i_in_dbl;
  assign w_any_ev = w_dbl_ev | w_sgl_ev;

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_pop    = ~w_empty & i_scrb_rdy;

`ifdef ECC_SCRUB_DEDUP_EN
  // Slot k is occupied when its distance from the read index is below the
  // occupancy; the head slot is excluded while it is leaving this cycle.
  logic [PTR_W-1:0] w_off;
  always_comb begin
    w_dedup_hit = '0;
    w_off       = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      w_off = PTR_W'(k) - w_rd_idx;
      if (({1'b0, w_off} < w_count) && (r_mem_addr[k] == i_in_addr) &&
          !(w_pop && (w_off == '0))) begin
        w_dedup_hit[k] = 1'b1;
      end
    end
  end
  assign w_dedup = w_sgl_ev & (|w_dedup_hit);
`else
  assign w_dedup_hit = '0;
  assign w_dedup     = 1'b0;
`endif

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push_req = w_sgl_ev & ~w_dedup;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Storage needs no reset: pointers alone define which slots are live
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_addr[w_wr_idx] <= i_in_addr;
      r_mem_data[w_wr_idx] <= i_in_data;
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (w_sgl_ev && w_dedup_hit[k]) begin
        r_mem_data[k] <= i_in_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Clear is applied first, then the same-cycle event lands on top of it
  assign w_sgl_base     = i_clr ? '0 : r_sgl_cnt;
  assign w_dbl_base     = i_clr ? '0 : r_dbl_cnt;
  assign w_log_vld_base = r_log_vld & ~i_clr;
  assign w_log_dbl_base = r_log_dbl & ~i_clr;
  assign w_log_cap      = (w_any_ev & ~w_log_vld_base) |
                          (w_dbl_ev & w_log_vld_base & ~w_log_dbl_base);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sgl_cnt  <= '0;
      r_dbl_cnt  <= '0;
      r_log_vld  <= 1'b0;
      r_log_dbl  <= 1'b0;
      r_log_addr <= '0;
      r_log_syn  <= '0;
      r_irq      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_sgl_cnt <= w_sgl_base + CNT_W'((w_sgl_ev && (w_sgl_base != CNT_MAX)) ? 1 : 0);
      r_dbl_cnt <= w_dbl_base + CNT_W'((w_dbl_ev && (w_dbl_base != CNT_MAX)) ? 1 : 0);
      r_irq     <= (r_irq & ~i_clr) | w_dbl_ev;
      r_drop    <= (r_drop & ~i_clr) | w_drop;
      if (w_log_cap) begin
        r_log_vld  <= 1'b1;
        r_log_dbl  <= w_dbl_ev;
        r_log_addr <= i_in_addr;
        r_log_syn  <= i_in_syn;
      end else if (i_clr) begin
        r_log_vld  <= 1'b0;
        r_log_dbl  <= 1'b0;
        r_log_addr <= '0;
        r_log_syn  <= '0;
      end
    end
  end

  // Head is gated so the request outputs read zero whenever nothing is queued
  assign o_scrb_vld  = ~w_empty;
  assign o_scrb_addr = w_empty ? '0 : r_mem_addr[w_rd_idx];
  assign o_scrb_data = w_empty ? '0 : r_mem_data[w_rd_idx];
  assign o_sgl_cnt   = r_sgl_cnt;
  assign o_dbl_cnt   = r_dbl_cnt;
  assign o_log_vld   = r_log_vld;
  assign o_log_addr  = r_log_addr;
  assign o_log_syn   = r_log_syn;
  assign o_log_dbl   = r_log_dbl;
  assign o_irq       = r_irq;
  assign o_drop      = r_drop;

endmodule

// File: tb/tb_ecc_32_err_scrub.sv
// tb/tb_ecc_32_err_scrub.sv - self-checking bench for ecc_32_err_scrub
module tb_ecc_32_err_scrub;

  localparam int AW    = 10;
  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_vld = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [38:0]   in_data = '0;
  logic [6:0]    in_syn = '0;
  logic          in_sgl = 1'b0;
  logic          in_dbl = 1'b0;
  logic          clr = 1'b0;
  logic          scrb_rdy = 1'b0;
  logic          scrb_vld;
  logic [AW-1:0] scrb_addr;
  logic [38:0]   scrb_data;
  logic [CW-1:0] sgl_cnt;
  logic [CW-1:0] dbl_cnt;
  logic          log_vld;
  logic [AW-1:0] log_addr;
  logic [6:0]    log_syn;
  logic          log_dbl;
  logic          irq;
  logic          drop;

  always #5 clk = ~clk;

  ecc_32_err_scrub #(.ADDR_W(AW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_in_vld(in_vld), .i_in_addr(in_addr),
    .i_in_data(in_data), .i_in_syn(in_syn), .i_in_sgl(in_sgl), .i_in_dbl(in_dbl),
    .i_clr(clr), .o_scrb_vld(scrb_vld), .i_scrb_rdy(scrb_rdy),
    .o_scrb_addr(scrb_addr), .o_scrb_data(scrb_data), .o_sgl_cnt(sgl_cnt),
    .o_dbl_cnt(dbl_cnt), .o_log_vld(log_vld), .o_log_addr(log_addr),
    .o_log_syn(log_syn), .o_log_dbl(log_dbl), .o_irq(irq), .o_drop(drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending requests plus plain counters/flags
  typedef struct packed {
    logic [AW-1:0] a;
    logic [38:0]   d;
  } ent_t;

  ent_t          mq[$];
  ent_t          m_tmp;
  int            m_sgl, m_dbl;
  bit            m_logv, m_logd, m_irq, m_drop;
  logic [AW-1:0] m_loga;
  logic [6:0]    m_logs;
  bit            m_pop, m_sev, m_dev, m_hit, m_full;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_sgl = 0; m_dbl = 0; m_logv = 0; m_logd = 0; m_irq = 0; m_drop = 0;
      m_loga = '0; m_logs = '0;
    end else begin
      m_pop  = (mq.size() > 0) && scrb_rdy;
      m_dev  = in_vld && in_dbl;
      m_sev  = in_vld && in_sgl && !in_dbl;
      m_full = (mq.size() >= DEPTH);
      if (clr) begin
        m_sgl = 0; m_dbl = 0; m_logv = 0; m_logd = 0; m_irq = 0; m_drop = 0;
        m_loga = '0; m_logs = '0;
      end
      if (m_dev) begin
        if (m_dbl < CMAX) m_dbl++;
        m_irq = 1;
      end
      if (m_sev && m_sgl < CMAX) m_sgl++;
      if ((m_sev || m_dev) && (!m_logv || (m_dev && !m_logd))) begin
        m_logv = 1; m_logd = m_dev; m_loga = in_addr; m_logs = in_syn;
      end
      m_hit = 0;
`ifdef ECC_SCRUB_DEDUP_EN
      if (m_sev) begin
        foreach (mq[i]) begin
          if (!(m_pop && i == 0) && mq[i].a == in_addr) begin
            mq[i].d = in_data;
            m_hit = 1;
          end
        end
      end
`endif
      if (m_pop) m_tmp = mq.pop_front();
      if (m_sev && !m_hit) begin
        if (!m_full || m_pop) mq.push_back('{a: in_addr, d: in_data});
        else m_drop = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      chk("scrb_vld", scrb_vld, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("scrb_addr", scrb_addr, mq[0].a);
        chk("scrb_data", scrb_data, mq[0].d);
      end
      chk("sgl_cnt", sgl_cnt, m_sgl);
      chk("dbl_cnt", dbl_cnt, m_dbl);
      chk("log_vld", log_vld, m_logv);
      if (m_logv) begin
        chk("log_addr", log_addr, m_loga);
        chk("log_syn", log_syn, m_logs);
        chk("log_dbl", log_dbl, m_logd);
      end
      chk("irq", irq, m_irq);
      chk("drop", drop, m_drop);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input logic [AW-1:0] a, input logic [38:0] d, input logic [6:0] s,
                    input logic sg, input logic db);
    in_vld = 1'b1; in_addr = a; in_data = d; in_syn = s; in_sgl = sg; in_dbl = db;
    @(posedge clk);
    #1;
    in_vld = 1'b0; in_sgl = 1'b0; in_dbl = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  int exp_a[4];

  initial begin
    #12;
    chk("rst_scrb_vld", scrb_vld, 0);
    chk("rst_scrb_addr", scrb_addr, 0);
    chk("rst_sgl_cnt", sgl_cnt, 0);
    chk("rst_dbl_cnt", dbl_cnt, 0);
    chk("rst_log_vld", log_vld, 0);
    chk("rst_irq", irq, 0);
    chk("rst_drop", drop, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1);

    // Single event, request visible the next cycle then popped
    scrb_rdy = 1'b1;
    ev(10'h005, 39'h0_0000_0001, 7'h03, 1'b1, 1'b0);
    chk("t1_vld", scrb_vld, 1);
    chk("t1_addr", scrb_addr, 10'h005);
    chk("t1_data", scrb_data, 39'h1);
    chk("t1_sgl", sgl_cnt, 1);
    chk("t1_logv", log_vld, 1);
    chk("t1_logd", log_dbl, 0);
    chk("t1_loga", log_addr, 10'h005);
    cyc(1);
    chk("t1_popped", scrb_vld, 0);

    // Double overwrites a single log entry; later single leaves it alone
    ev(10'h010, 39'h10, 7'h05, 1'b1, 1'b0);
    ev(10'h020, 39'h20, 7'h41, 1'b0, 1'b1);
    chk("t2_dbl", dbl_cnt, 1);
    chk("t2_irq", irq, 1);
    chk("t2_loga", log_addr, 10'h020);
    chk("t2_logs", log_syn, 7'h41);
    chk("t2_logd", log_dbl, 1);
    ev(10'h030, 39'h30, 7'h06, 1'b1, 1'b0);
    chk("t2_loga_hold", log_addr, 10'h020);
    chk("t2_logd_hold", log_dbl, 1);
    cyc(3);

    // Five singles into a stalled queue: the fifth is dropped
    scrb_rdy = 1'b0;
    clr_pulse();
    chk("t3_clr_sgl", sgl_cnt, 0);
    chk("t3_clr_irq", irq, 0);
    chk("t3_clr_logv", log_vld, 0);
    for (int i = 1; i <= 5; i++) ev(AW'(i), 39'h100 + 39'(i), 7'(i), 1'b1, 1'b0);
    chk("t3_drop", drop, 1);
    chk("t3_sgl", sgl_cnt, 5);
    chk("t3_head", scrb_addr, 10'h001);
    chk("t3_model_occ", mq.size(), 4);

    // Full queue, push and pop in the same cycle
    clr_pulse();
    chk("t4_drop_clr", drop, 0);
    scrb_rdy = 1'b1;
    ev(10'h006, 39'h106, 7'h07, 1'b1, 1'b0);
    scrb_rdy = 1'b0;
    chk("t4_drop", drop, 0);
    chk("t4_head", scrb_addr, 10'h002);
    chk("t4_model_occ", mq.size(), 4);
    exp_a = '{2, 3, 4, 6};
    scrb_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_addr", scrb_addr, exp_a[i]);
      cyc(1);
    end
    chk("t4_empty", scrb_vld, 0);

    // Saturation, then clear with a same-cycle single
    clr_pulse();
    for (int i = 0; i < 16; i++) ev(10'h040 + AW'(i), 39'h200 + 39'(i), 7'h01, 1'b1, 1'b0);
    chk("t5_sat", sgl_cnt, 15);
    clr = 1'b1;
    ev(10'h060, 39'h260, 7'h09, 1'b1, 1'b0);
    clr = 1'b0;
    chk("t5_clr_ev_sgl", sgl_cnt, 1);
    chk("t5_clr_ev_logv", log_vld, 1);
    chk("t5_clr_ev_loga", log_addr, 10'h060);
    cyc(3);

    // Asynchronous reset mid-operation
    scrb_rdy = 1'b0;
    ev(10'h070, 39'h370, 7'h02, 1'b1, 1'b0);
    ev(10'h071, 39'h371, 7'h02, 1'b1, 1'b0);
    chk("t6_vld_pre", scrb_vld, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk("t6_vld_async", scrb_vld, 0);
    chk("t6_sgl_async", sgl_cnt, 0);
    chk("t6_addr_async", scrb_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1);

    // Same address twice into a stalled queue
    ev(10'h007, 39'h12_3456_789A, 7'h11, 1'b1, 1'b0);
    ev(10'h007, 39'h55_AAAA_5555, 7'h11, 1'b1, 1'b0);
    chk("t7_sgl", sgl_cnt, 2);
    chk("t7_vld", scrb_vld, 1);
`ifdef ECC_SCRUB_DEDUP_EN
    chk("t7_data", scrb_data, 39'h55_AAAA_5555);
    chk("t7_model_occ", mq.size(), 1);
    scrb_rdy = 1'b1;
    cyc(1);
    chk("t7_empty", scrb_vld, 0);
`else
    chk("t7_data_a", scrb_data, 39'h12_3456_789A);
    chk("t7_model_occ", mq.size(), 2);
    scrb_rdy = 1'b1;
    cyc(1);
    chk("t7_data_b", scrb_data, 39'h55_AAAA_5555);
    cyc(1);
    chk("t7_empty", scrb_vld, 0);
`endif
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
